// File: rtl/vga_timing_core.sv
// Parametrised VGA timing generator. Counters advance on a pixel enable. Sync and
// display flags can be delayed by a pixel-step pipeline. Also provides line/frame strobes.
module vga_timing_core #(
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned H_SYNC_POL = 1,
    parameter int unsigned V_SYNC_POL = 1,
    parameter int unsigned CNT_W      = 10,
    parameter int unsigned OUT_DELAY  = 0,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    output logic [CNT_W-1:0]   hpos,
    output logic [CNT_W-1:0]   vpos,
    output logic               hsync,
    output logic               vsync,
    output logic               display_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
    localparam logic HS_IDLE = (H_SYNC_POL == 0);
    localparam logic VS_IDLE = (V_SYNC_POL == 0);

    if ((CNT_W > 32) || (64'(H_TOTAL - 1) > CNT_MAX) || (64'(V_TOTAL - 1) > CNT_MAX)
        || (OUT_DELAY > 7)) begin : g_bad_params
        $fatal(1, "vga_timing_core: illegal CNT_W/timing/OUT_DELAY parameters");
    end

    logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               h_last, v_last;

    assign h_last = (h_q == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_q == CNT_W'(V_TOTAL - 1));

    // Raster advance: line wrap and frame wrap share the same pixel step.
    always_comb begin
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;
        if (pix_ce) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            if (h_last) begin
                v_d = v_last ? '0 : v_q + 1'b1;
                if (v_last) begin
                    frame_d = frame_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    logic hs_raw, vs_raw, de_raw, hs_lvl, vs_lvl;

    assign hs_raw = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    assign vs_raw = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
    assign de_raw = (32'(h_q) < H_DISPLAY) && (32'(v_q) < V_DISPLAY);
    assign hs_lvl = hs_raw ^ HS_IDLE;
    assign vs_lvl = vs_raw ^ VS_IDLE;

    if (OUT_DELAY == 0) begin : g_nodelay
        assign hsync      = hs_lvl;
        assign vsync      = vs_lvl;
        assign display_on = de_raw;
    end else begin : g_delay
        logic [OUT_DELAY-1:0] hs_q, vs_q, de_q;

        // Pixel-step shift register; stage i holds the decode from i+1 steps ago.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hs_q <= {OUT_DELAY{HS_IDLE}};
                vs_q <= {OUT_DELAY{VS_IDLE}};
                de_q <= '0;
            end else if (pix_ce) begin
                hs_q[0] <= hs_lvl;
                vs_q[0] <= vs_lvl;
                de_q[0] <= de_raw;
                for (int i = 1; i < OUT_DELAY; i++) begin
                    hs_q[i] <= hs_q[i-1];
                    vs_q[i] <= vs_q[i-1];
                    de_q[i] <= de_q[i-1];
                end
            end
        end

        assign hsync      = hs_q[OUT_DELAY-1];
        assign vsync      = vs_q[OUT_DELAY-1];
        assign display_on = de_q[OUT_DELAY-1];
    end

    assign hpos        = h_q;
    assign vpos        = v_q;
    assign line_start  = pix_ce && (h_q == '0);
    assign frame_start = line_start && (v_q == '0);
    assign frame_count = frame_q;

endmodule

// File: tb/tb_vga_timing_core.sv
// Directed bench for vga_timing_core: default, delayed, inverted-polarity,
// tiny-timing and short-line/default-vertical instances share clk, reset and pix_ce.
module tb_vga_timing_core;

    logic clk = 1'b0;
    logic reset;
    logic pix_ce;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    logic [9:0] def_hpos, def_vpos, d3_hpos, d3_vpos, np_hpos, np_vpos;
    logic [9:0] s_hpos, s_vpos, v_hpos, v_vpos;
    logic       def_hs, def_vs, def_de, def_ls, def_fs;
    logic       d3_hs, d3_vs, d3_de, d3_ls, d3_fs;
    logic       np_hs, np_vs, np_de, np_ls, np_fs;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic       v_hs, v_vs, v_de, v_ls, v_fs;
    logic [7:0] def_fc, d3_fc, np_fc, v_fc;
    logic [1:0] s_fc;

    vga_timing_core dut_def (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .hpos(def_hpos), .vpos(def_vpos),
        .hsync(def_hs), .vsync(def_vs), .display_on(def_de), .line_start(def_ls),
        .frame_start(def_fs), .frame_count(def_fc));

    vga_timing_core #(.OUT_DELAY(3)) dut_d3 (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .hpos(d3_hpos), .vpos(d3_vpos),
        .hsync(d3_hs), .vsync(d3_vs), .display_on(d3_de), .line_start(d3_ls),
        .frame_start(d3_fs), .frame_count(d3_fc));

    vga_timing_core #(.H_SYNC_POL(0), .V_SYNC_POL(0)) dut_np (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .hpos(np_hpos), .vpos(np_vpos),
        .hsync(np_hs), .vsync(np_vs), .display_on(np_de), .line_start(np_ls),
        .frame_start(np_fs), .frame_count(np_fc));

    vga_timing_core #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                      .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                      .FRAME_W(2)) dut_s (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .hpos(s_hpos), .vpos(s_vpos),
        .hsync(s_hs), .vsync(s_vs), .display_on(s_de), .line_start(s_ls),
        .frame_start(s_fs), .frame_count(s_fc));

    vga_timing_core #(.H_DISPLAY(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1)) dut_v (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .hpos(v_hpos), .vpos(v_vpos),
        .hsync(v_hs), .vsync(v_vs), .display_on(v_de), .line_start(v_ls),
        .frame_start(v_fs), .frame_count(v_fc));

    task automatic apply_reset();
        reset  = 1'b1;
        pix_ce = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        pix_ce = 1'b0;
        #3;
        tests_run++;
        if (def_hpos !== 10'd0 || def_vpos !== 10'd0 || def_fc !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_counters: got h=%0d v=%0d fc=%0d exp 0/0/0", def_hpos, def_vpos, def_fc);
        end
        tests_run++;
        if (def_hs !== 1'b0 || def_vs !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sync_pos: got hs=%b vs=%b exp 0/0", def_hs, def_vs);
        end
        tests_run++;
        if (d3_de !== 1'b0 || d3_hs !== 1'b0 || d3_vs !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_delay_stages: got de=%b hs=%b vs=%b exp 0/0/0", d3_de, d3_hs, d3_vs);
        end
        tests_run++;
        if (np_hs !== 1'b1 || np_vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sync_neg: got hs=%b vs=%b exp 1/1", np_hs, np_vs);
        end
        tests_run++;
        if (s_fc !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_small_fc: got %0d exp 0", s_fc);
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        pix_ce = 1'b1;
        @(negedge clk);
        tests_run++;
        if (def_ls !== 1'b1 || def_fs !== 1'b1 || def_hpos !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_first_strobe: got ls=%b fs=%b h=%0d exp 1/1/0", def_ls, def_fs, def_hpos);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (def_hpos !== 10'd1) begin
            tests_failed++;
            $display("FAIL reset_first_step: got h=%0d exp 1", def_hpos);
        end
    endtask

    task automatic test_hsync_window();
        apply_reset();
        pix_ce = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            int h;
            int v;
            h = i % 800;
            v = i / 800;
            @(negedge clk);
            tests_run++;
            if (def_hpos !== 10'(h) || def_vpos !== 10'(v)) begin
                tests_failed++;
                $display("FAIL hwin_pos i=%0d: got %0d,%0d exp %0d,%0d", i, def_hpos, def_vpos, h, v);
            end
            tests_run++;
            if (def_hs !== (h >= 656 && h < 752)) begin
                tests_failed++;
                $display("FAIL hwin_hsync h=%0d: got %b", h, def_hs);
            end
            tests_run++;
            if (def_de !== (h < 640 && v < 480)) begin
                tests_failed++;
                $display("FAIL hwin_de h=%0d v=%0d: got %b", h, v, def_de);
            end
            tests_run++;
            if (def_ls !== (h == 0) || def_fs !== (h == 0 && v == 0)) begin
                tests_failed++;
                $display("FAIL hwin_strobes i=%0d: got ls=%b fs=%b", i, def_ls, def_fs);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_vertical();
        apply_reset();
        pix_ce = 1'b1;
        for (int i = 0; i < 7351; i++) begin
            int v;
            v = (i / 7) % 525;
            @(negedge clk);
            tests_run++;
            if (v_hpos !== 10'(i % 7) || v_vpos !== 10'(v)) begin
                tests_failed++;
                $display("FAIL vert_pos i=%0d: got %0d,%0d exp %0d,%0d", i, v_hpos, v_vpos, i % 7, v);
            end
            tests_run++;
            if (v_vs !== (v >= 490 && v < 492)) begin
                tests_failed++;
                $display("FAIL vert_vsync v=%0d: got %b", v, v_vs);
            end
            tests_run++;
            if (v_fs !== (i % 3675 == 0)) begin
                tests_failed++;
                $display("FAIL vert_frame_start i=%0d: got %b", i, v_fs);
            end
            tests_run++;
            if (v_fc !== 8'(i / 3675)) begin
                tests_failed++;
                $display("FAIL vert_frame_count i=%0d: got %0d exp %0d", i, v_fc, i / 3675);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_pix_ce_half();
        int s;
        int last_ls;
        apply_reset();
        s = 0;
        last_ls = -1;
        for (int i = 0; i < 3200; i++) begin
            logic pce;
            int   h;
            int   t;
            pce    = (i % 2 == 0);
            pix_ce = pce;
            h      = s % 800;
            t      = s - 3;
            @(negedge clk);
            tests_run++;
            if (def_hpos !== 10'(h) || def_vpos !== 10'(s / 800)) begin
                tests_failed++;
                $display("FAIL half_pos i=%0d: got %0d,%0d exp %0d,%0d", i, def_hpos, def_vpos, h, s / 800);
            end
            tests_run++;
            if (def_hs !== (h >= 656 && h < 752)) begin
                tests_failed++;
                $display("FAIL half_hsync i=%0d: got %b", i, def_hs);
            end
            tests_run++;
            if (def_ls !== (pce && h == 0) || def_fs !== (pce && s == 0)) begin
                tests_failed++;
                $display("FAIL half_strobes i=%0d: got ls=%b fs=%b", i, def_ls, def_fs);
            end
            tests_run++;
            if (d3_de !== (t >= 0 && (t % 800) < 640)) begin
                tests_failed++;
                $display("FAIL half_delay_de i=%0d step=%0d: got %b", i, s, d3_de);
            end
            if (def_ls === 1'b1) begin
                if (last_ls >= 0) begin
                    tests_run++;
                    if (i - last_ls != 1600) begin
                        tests_failed++;
                        $display("FAIL half_line_period: got %0d exp 1600", i - last_ls);
                    end
                end
                last_ls = i;
            end
            @(posedge clk);
            #1;
            if (pce) s++;
        end
    endtask

    task automatic test_delay();
        apply_reset();
        pix_ce = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            int  h3;
            int  v3;
            logic de_e;
            logic hs_e;
            h3   = (i - 3) % 800;
            v3   = (i - 3) / 800;
            de_e = (i >= 3) && h3 < 640 && v3 < 480;
            hs_e = (i >= 3) && h3 >= 656 && h3 < 752;
            @(negedge clk);
            tests_run++;
            if (d3_hpos !== 10'(i % 800)) begin
                tests_failed++;
                $display("FAIL delay_hpos i=%0d: got %0d exp %0d", i, d3_hpos, i % 800);
            end
            tests_run++;
            if (d3_de !== de_e) begin
                tests_failed++;
                $display("FAIL delay_de i=%0d: got %b exp %b", i, d3_de, de_e);
            end
            tests_run++;
            if (d3_hs !== hs_e || d3_vs !== 1'b0) begin
                tests_failed++;
                $display("FAIL delay_sync i=%0d: got hs=%b vs=%b exp %b/0", i, d3_hs, d3_vs, hs_e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_polarity();
        apply_reset();
        pix_ce = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            tests_run++;
            if (np_hs !== !(i >= 656 && i < 752) || np_vs !== 1'b1) begin
                tests_failed++;
                $display("FAIL polarity h=%0d: got hs=%b vs=%b", i, np_hs, np_vs);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_frame_count();
        apply_reset();
        pix_ce = 1'b1;
        for (int i = 0; i < 175; i++) begin
            int v;
            v = (i / 7) % 5;
            @(negedge clk);
            tests_run++;
            if (s_fc !== 2'((i / 35) % 4)) begin
                tests_failed++;
                $display("FAIL small_frame_count i=%0d: got %0d exp %0d", i, s_fc, (i / 35) % 4);
            end
            tests_run++;
            if (s_fs !== (i % 35 == 0) || s_vs !== (v == 3) || s_hs !== (i % 7 == 5)) begin
                tests_failed++;
                $display("FAIL small_timing i=%0d: got fs=%b vs=%b hs=%b", i, s_fs, s_vs, s_hs);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        pix_ce = 1'b1;
        repeat (1100) @(posedge clk);
        #1;
        tests_run++;
        if (def_hpos !== 10'd300 || def_vpos !== 10'd1 || d3_de !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_pre: got h=%0d v=%0d de3=%b exp 300/1/1", def_hpos, def_vpos, d3_de);
        end
        reset = 1'b1;
        #2;
        tests_run++;
        if (def_hpos !== 10'd0 || def_vpos !== 10'd0 || def_fc !== 8'd0) begin
            tests_failed++;
            $display("FAIL arst_counters: got h=%0d v=%0d exp 0/0", def_hpos, def_vpos);
        end
        tests_run++;
        if (d3_de !== 1'b0 || d3_hs !== 1'b0 || np_hs !== 1'b1 || np_vs !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_outputs: got de3=%b hs3=%b nhs=%b nvs=%b", d3_de, d3_hs, np_hs, np_vs);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (def_ls !== 1'b1 || def_fs !== 1'b1 || def_hpos !== 10'd0) begin
            tests_failed++;
            $display("FAIL arst_release_strobe: got ls=%b fs=%b h=%0d", def_ls, def_fs, def_hpos);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (def_hpos !== 10'd1 || def_ls !== 1'b0) begin
            tests_failed++;
            $display("FAIL arst_resume: got h=%0d ls=%b exp 1/0", def_hpos, def_ls);
        end
    endtask

    initial begin
        reset  = 1'b1;
        pix_ce = 1'b0;
        test_reset();
        test_hsync_window();
        test_vertical();
        test_pix_ce_half();
        test_delay();
        test_polarity();
        test_frame_count();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
